// File: rtl/key_schedule_gen_if.sv
// Bus bundle for key_schedule_gen: key load handshake, cipher-core streams, schedule outputs.
// The rk_addr/rk_data read port exists only when KEY_SCHED_RDPORT_EN is defined.
interface key_schedule_gen_if #(
  parameter int ROUND_NUM  = 32,
  parameter int BLOCK_SIZE = 64,
  parameter int KEY_WORDS  = 2
);
  localparam int RK_W = BLOCK_SIZE * 3 / 4;
  localparam int AW   = (ROUND_NUM > 1) ? $clog2(ROUND_NUM) : 1;

  logic [KEY_WORDS*BLOCK_SIZE-1:0] key;
  logic                            key_valid;
  logic                            key_ready;

  logic [BLOCK_SIZE-1:0]           m_axis_tdata;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;

  logic [BLOCK_SIZE-1:0]           s_axis_tdata;
  logic                            s_axis_tvalid;
  logic                            s_axis_tready;

  logic [0:ROUND_NUM-1][RK_W-1:0]  round_keys;
  logic                            keys_valid;
  logic                            busy;

`ifdef KEY_SCHED_RDPORT_EN
  logic [AW-1:0]                   rk_addr;
  logic [RK_W-1:0]                 rk_data;

  modport master (
    input  key, key_valid, m_axis_tready, s_axis_tdata, s_axis_tvalid, rk_addr,
    output key_ready, m_axis_tdata, m_axis_tvalid, s_axis_tready,
           round_keys, keys_valid, busy, rk_data
  );
  modport slave (
    output key, key_valid, m_axis_tready, s_axis_tdata, s_axis_tvalid, rk_addr,
    input  key_ready, m_axis_tdata, m_axis_tvalid, s_axis_tready,
           round_keys, keys_valid, busy, rk_data
  );
`else
  modport master (
    input  key, key_valid, m_axis_tready, s_axis_tdata, s_axis_tvalid,
    output key_ready, m_axis_tdata, m_axis_tvalid, s_axis_tready,
           round_keys, keys_valid, busy
  );
  modport slave (
    output key, key_valid, m_axis_tready, s_axis_tdata, s_axis_tvalid,
    input  key_ready, m_axis_tdata, m_axis_tvalid, s_axis_tready,
           round_keys, keys_valid, busy
  );
`endif
endinterface

// File: rtl/key_schedule_gen.sv
// MacGuffin key-schedule generator: chains each key word through an external cipher core and
// XOR-accumulates the round keys. KEY_SCHED_RDPORT_EN adds a registered round-key read port.
//
// state | meaning
// IDLE  | no schedule yet, key accepted
// SEND  | block offered to cipher core
// WAIT  | waiting for cipher core result
// DONE  | schedule complete and stable, re-key accepted
module key_schedule_gen #(
  parameter int ROUND_NUM  = 32,
  parameter int BLOCK_SIZE = 64,
  parameter int KEY_WORDS  = 2
) (
  input logic                clk,
  input logic                rst_n,
  key_schedule_gen_if.master bus
);
  localparam int RK_W   = BLOCK_SIZE * 3 / 4;
  localparam int KEY_W  = KEY_WORDS * BLOCK_SIZE;
  localparam int CNT_W  = (ROUND_NUM > 1) ? $clog2(ROUND_NUM) : 1;
  localparam int PASS_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(ROUND_NUM - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(KEY_WORDS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_DONE} state_t;

  state_t                         state_q, state_d;
  logic [KEY_W-1:0]               key_q, key_d;
  logic [PASS_W-1:0]              pass_q, pass_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [BLOCK_SIZE-1:0]          block_q, block_d;
  logic [0:ROUND_NUM-1][RK_W-1:0] rk_q;

  logic                           rk_we;
  logic [RK_W-1:0]                rk_new;
  logic [RK_W-1:0]                rk_wdata;
  logic [PASS_W-1:0]              next_pass;
  logic [BLOCK_SIZE-1:0]          next_word;

  // next_pass wraps so every key word stays addressable by the selector below
  assign next_pass = (pass_q == LAST_PASS) ? '0 : pass_q + PASS_W'(1);

  always_comb begin
    next_word = '0;
    for (int w = 0; w < KEY_WORDS; w++) begin
      if (PASS_W'(w) == next_pass) next_word = key_q[KEY_W-1-w*BLOCK_SIZE -: BLOCK_SIZE];
    end
  end

  assign rk_new   = bus.s_axis_tdata[BLOCK_SIZE-1 -: RK_W];
  assign rk_wdata = (pass_q == '0) ? rk_new : (rk_q[cnt_q] ^ rk_new);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    block_d = block_q;
    rk_we   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.key_valid) begin
          key_d   = bus.key;
          pass_d  = '0;
          cnt_d   = '0;
          block_d = bus.key[KEY_W-1 -: BLOCK_SIZE];
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.m_axis_tready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.s_axis_tvalid) begin
          rk_we   = 1'b1;
          block_d = bus.s_axis_tdata;
          if (cnt_q != LAST_CNT) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_SEND;
          end else if (pass_q != LAST_PASS) begin
            pass_d  = next_pass;
            cnt_d   = '0;
            block_d = next_word;
            state_d = ST_SEND;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      pass_q  <= '0;
      cnt_q   <= '0;
      block_q <= '0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
      if (rk_we) rk_q[cnt_q] <= rk_wdata;
    end
  end

  assign bus.key_ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign bus.m_axis_tvalid = (state_q == ST_SEND);
  assign bus.m_axis_tdata  = block_q;
  assign bus.s_axis_tready = (state_q == ST_WAIT);
  assign bus.busy          = (state_q == ST_SEND) || (state_q == ST_WAIT);
  assign bus.keys_valid    = (state_q == ST_DONE);
  assign bus.round_keys    = rk_q;

`ifdef KEY_SCHED_RDPORT_EN
  logic [RK_W-1:0] rk_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_data_q <= '0;
    end else if ({1'b0, bus.rk_addr} < (CNT_W+1)'(ROUND_NUM)) begin
      rk_data_q <= rk_q[bus.rk_addr];
    end else begin
      rk_data_q <= '0;
    end
  end

  assign bus.rk_data = rk_data_q;
`endif
endmodule

// File: tb/tb_key_schedule_gen.sv
// Directed bench for key_schedule_gen: small (4x1) and default (32x2) builds with stub cipher cores,
// plus a 24-round build exercising the read port when KEY_SCHED_RDPORT_EN is defined.
module tb_key_schedule_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  key_schedule_gen_if #(.ROUND_NUM(4), .BLOCK_SIZE(64), .KEY_WORDS(1)) sm_if ();
  key_schedule_gen #(.ROUND_NUM(4), .BLOCK_SIZE(64), .KEY_WORDS(1)) u_sm (
    .clk(clk), .rst_n(rst_n), .bus(sm_if));

  key_schedule_gen_if #(.ROUND_NUM(32), .BLOCK_SIZE(64), .KEY_WORDS(2)) bg_if ();
  key_schedule_gen #(.ROUND_NUM(32), .BLOCK_SIZE(64), .KEY_WORDS(2)) u_bg (
    .clk(clk), .rst_n(rst_n), .bus(bg_if));

`ifdef KEY_SCHED_RDPORT_EN
  key_schedule_gen_if #(.ROUND_NUM(24), .BLOCK_SIZE(64), .KEY_WORDS(1)) rd_if ();
  key_schedule_gen #(.ROUND_NUM(24), .BLOCK_SIZE(64), .KEY_WORDS(1)) u_rd (
    .clk(clk), .rst_n(rst_n), .bus(rd_if));
`endif

  int  sm_mode = 0;
  int  bg_mode = 1;
  int  rd_mode = 2;
  bit  bg_stall = 1'b0;
  bit  bg_prev_stall = 1'b0;
  logic [63:0] bg_prev_tdata = '0;
  logic [47:0] exp_rk [32];

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] core_f(input int mode, input logic [63:0] x);
    case (mode)
      0:       return x + 64'd1;
      1:       return x ^ 64'hA5A5_A5A5_A5A5_A5A5;
      default: return {x[59:0], x[63:60]} ^ 64'hA5A5_A5A5_A5A5_A5A5;
    endcase
  endfunction

  // Stub cipher cores: respond to the block currently offered; bg core optionally stalls.
  always @(negedge clk) begin
    sm_if.m_axis_tready = 1'b1;
    sm_if.s_axis_tvalid = 1'b1;
    sm_if.s_axis_tdata  = core_f(sm_mode, sm_if.m_axis_tdata);
    if (bg_prev_stall) begin
      check_val("stall_tvalid", 128'(bg_if.m_axis_tvalid), 128'(1));
      check_val("stall_tdata", 128'(bg_if.m_axis_tdata), 128'(bg_prev_tdata));
    end
    bg_if.m_axis_tready = bg_stall ? 1'($urandom_range(1)) : 1'b1;
    bg_if.s_axis_tvalid = bg_stall ? 1'($urandom_range(1)) : 1'b1;
    bg_if.s_axis_tdata  = core_f(bg_mode, bg_if.m_axis_tdata);
    bg_prev_stall = bg_if.m_axis_tvalid && !bg_if.m_axis_tready;
    bg_prev_tdata = bg_if.m_axis_tdata;
`ifdef KEY_SCHED_RDPORT_EN
    rd_if.m_axis_tready = 1'b1;
    rd_if.s_axis_tvalid = 1'b1;
    rd_if.s_axis_tdata  = core_f(rd_mode, rd_if.m_axis_tdata);
`endif
  end

  function automatic logic get_kv(input int w);
`ifdef KEY_SCHED_RDPORT_EN
    if (w == 2) return rd_if.keys_valid;
`endif
    return (w == 0) ? sm_if.keys_valid : bg_if.keys_valid;
  endfunction

  function automatic logic get_ready(input int w);
`ifdef KEY_SCHED_RDPORT_EN
    if (w == 2) return rd_if.key_ready;
`endif
    return (w == 0) ? sm_if.key_ready : bg_if.key_ready;
  endfunction

  function automatic logic get_busy(input int w);
`ifdef KEY_SCHED_RDPORT_EN
    if (w == 2) return rd_if.busy;
`endif
    return (w == 0) ? sm_if.busy : bg_if.busy;
  endfunction

  function automatic logic [47:0] get_rk(input int w, input int c);
`ifdef KEY_SCHED_RDPORT_EN
    if (w == 2) return rd_if.round_keys[c];
`endif
    return (w == 0) ? sm_if.round_keys[c] : bg_if.round_keys[c];
  endfunction

  task automatic drive_key(input int w, input logic [127:0] k, input logic v);
    if (w == 0) begin sm_if.key = k[63:0]; sm_if.key_valid = v; end
    if (w == 1) begin bg_if.key = k; bg_if.key_valid = v; end
`ifdef KEY_SCHED_RDPORT_EN
    if (w == 2) begin rd_if.key = k[63:0]; rd_if.key_valid = v; end
`endif
  endtask

  task automatic build_model(input logic [127:0] k, input int rounds, input int words, input int mode);
    logic [63:0] blk;
    logic [47:0] r;
    for (int c = 0; c < 32; c++) exp_rk[c] = '0;
    for (int p = 0; p < words; p++) begin
      blk = k[(words-1-p)*64 +: 64];
      for (int c = 0; c < rounds; c++) begin
        blk = core_f(mode, blk);
        r = blk[63:16];
        exp_rk[c] = (p == 0) ? r : (exp_rk[c] ^ r);
      end
    end
  endtask

  task automatic compare_sched(input int w, input int rounds, input string tag);
    for (int c = 0; c < rounds; c++)
      check_val($sformatf("%s_rk%0d", tag, c), 128'(get_rk(w, c)), 128'(exp_rk[c]));
  endtask

  // Accept a key, then count cycles until keys_valid; cycle 0 is the accepting cycle.
  task automatic load_and_wait(input int w, input logic [127:0] k, input int exp_lat,
                               input bit chk_old, input bit pulse, input logic [127:0] k2);
    int n;
    bit done;
    @(negedge clk);
    check_val("key_ready_idle", 128'(get_ready(w)), 128'(1));
    drive_key(w, k, 1'b1);
    @(posedge clk);
    #1;
    drive_key(w, k, 1'b0);
    check_val("kv_fall", 128'(get_kv(w)), 128'(0));
    check_val("busy_after_accept", 128'(get_busy(w)), 128'(1));
    if (chk_old) check_val("old_rk0_visible", 128'(get_rk(w, 0)), 128'(exp_rk[0]));
    n = 1;
    done = 1'b0;
    while (!done && n < 5000) begin
      @(negedge clk);
      if (get_kv(w)) begin
        done = 1'b1;
      end else begin
        if (pulse && n == 10) begin
          check_val("key_ready_busy", 128'(get_ready(w)), 128'(0));
          drive_key(w, k2, 1'b1);
        end else begin
          drive_key(w, k, 1'b0);
        end
        @(posedge clk);
        n++;
      end
    end
    drive_key(w, k, 1'b0);
    check_val("keys_valid_done", 128'(get_kv(w)), 128'(1));
    if (exp_lat > 0) check_val("latency", 128'(n), 128'(exp_lat));
  endtask

  localparam logic [127:0] KEY_A = {64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_0F0F_0F0F};
  localparam logic [127:0] KEY_B = {64'hDEAD_BEEF_CAFE_F00D, 64'h1357_9BDF_2468_ACE0};
  localparam logic [127:0] KEY_C = {64'h0000_1111_2222_3333, 64'h8888_9999_AAAA_BBBB};

  initial begin
    drive_key(0, '0, 1'b0);
    drive_key(1, '0, 1'b0);
`ifdef KEY_SCHED_RDPORT_EN
    drive_key(2, '0, 1'b0);
    sm_if.rk_addr = '0;
    bg_if.rk_addr = '0;
    rd_if.rk_addr = '0;
`endif
    #12;
    check_val("rst_key_ready", 128'(bg_if.key_ready), 128'(1));
    check_val("rst_keys_valid", 128'(bg_if.keys_valid), 128'(0));
    check_val("rst_busy", 128'(bg_if.busy), 128'(0));
    check_val("rst_m_tvalid", 128'(bg_if.m_axis_tvalid), 128'(0));
    check_val("rst_s_tready", 128'(bg_if.s_axis_tready), 128'(0));
    check_val("rst_rk0", 128'(bg_if.round_keys[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // small build, +1 core
    load_and_wait(0, 128'h0, 9, 1'b0, 1'b0, '0);
    build_model(128'h0, 4, 1, 0);
    compare_sched(0, 4, "sm_zero");
    check_val("sm_zero_rk3_hand", 128'(sm_if.round_keys[3]), 128'(48'h0));
    load_and_wait(0, 128'hFFFF_FFFF_FFFF_0000, 9, 1'b0, 1'b0, '0);
    check_val("sm_ones_rk0_hand", 128'(sm_if.round_keys[0]), 128'(48'hFFFF_FFFF_FFFF));
    build_model(128'hFFFF_FFFF_FFFF_0000, 4, 1, 0);
    compare_sched(0, 4, "sm_ones");

    // asynchronous reset in the middle of a WAIT state
    @(negedge clk);
    drive_key(0, 128'h1234_5678_9ABC_0000, 1'b1);
    @(posedge clk);
    #1;
    drive_key(0, 128'h0, 1'b0);
    repeat (4) @(negedge clk);
    check_val("pre_rst_wait", 128'(sm_if.s_axis_tready), 128'(1));
    check_val("pre_rst_rk0", 128'(sm_if.round_keys[0]), 128'(48'h1234_5678_9ABC));
    #1;
    rst_n = 1'b0;
    #1;
    check_val("arst_key_ready", 128'(sm_if.key_ready), 128'(1));
    check_val("arst_busy", 128'(sm_if.busy), 128'(0));
    check_val("arst_s_tready", 128'(sm_if.s_axis_tready), 128'(0));
    check_val("arst_m_tvalid", 128'(sm_if.m_axis_tvalid), 128'(0));
    check_val("arst_m_tdata", 128'(sm_if.m_axis_tdata), 128'(0));
    check_val("arst_rk0", 128'(sm_if.round_keys[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // default build, XOR-A5 core: every entry is top48(w0)^top48(w1)
    bg_mode = 1;
    load_and_wait(1, KEY_A, 129, 1'b0, 1'b0, '0);
    check_val("bg_a5_rk0_hand", 128'(bg_if.round_keys[0]), 128'(48'h0E2C_4A68_86A4));
    check_val("bg_a5_rk31_hand", 128'(bg_if.round_keys[31]), 128'(48'h0E2C_4A68_86A4));
    build_model(KEY_A, 32, 2, 1);
    compare_sched(1, 32, "bg_a5");

    // re-key from DONE with a rotating core, no stalls
    bg_mode = 2;
    load_and_wait(1, KEY_B, 129, 1'b1, 1'b0, '0);
    build_model(KEY_B, 32, 2, 2);
    compare_sched(1, 32, "bg_nostall");

    // same key under random stalls, with a key offered while busy
    bg_stall = 1'b1;
    load_and_wait(1, KEY_B, 0, 1'b1, 1'b1, KEY_C);
    bg_stall = 1'b0;
    compare_sched(1, 32, "bg_stall");

    load_and_wait(1, KEY_C, 129, 1'b1, 1'b0, '0);
    build_model(KEY_C, 32, 2, 2);
    compare_sched(1, 32, "bg_rekey");

`ifdef KEY_SCHED_RDPORT_EN
    load_and_wait(2, 128'h0F1E_2D3C_4B5A_6978, 49, 1'b0, 1'b0, '0);
    build_model(128'h0F1E_2D3C_4B5A_6978, 24, 1, 2);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      rd_if.rk_addr = 5'(a);
      @(posedge clk);
      #1;
      check_val($sformatf("rd_addr%0d", a), 128'(rd_if.rk_data), (a < 24) ? 128'(exp_rk[a]) : 128'(0));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
